// File: rtl/yacht_pkg.sv
// Shared constants for the Yacht scorecard controller.
package yacht_pkg;
    localparam int NUM_CAT = 12;
    localparam int SCORE_W = 8;
    localparam int TOTAL_W = 9;

    localparam logic [3:0] CAT_ACES   = 4'd0;
    localparam logic [3:0] CAT_TWOS   = 4'd1;
    localparam logic [3:0] CAT_THREES = 4'd2;
    localparam logic [3:0] CAT_FOURS  = 4'd3;
    localparam logic [3:0] CAT_FIVES  = 4'd4;
    localparam logic [3:0] CAT_SIXES  = 4'd5;
    localparam logic [3:0] CAT_CHOICE = 4'd6;
    localparam logic [3:0] CAT_FOURK  = 4'd7;
    localparam logic [3:0] CAT_FULLH  = 4'd8;
    localparam logic [3:0] CAT_SSTR   = 4'd9;
    localparam logic [3:0] CAT_LSTR   = 4'd10;
    localparam logic [3:0] CAT_YACHT  = 4'd11;
    localparam logic [3:0] CAT_NONE   = 4'hF;

    localparam int BONUS_THRESH = 63;
    localparam int BONUS_VAL    = 35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/yacht_player_card.sv
// One player's scorecard: used mask and running total.
// YACHT_UPPER_BONUS_EN adds the upper-section sum and the one-shot bonus.
module yacht_player_card
    import yacht_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               we,
    input  logic [3:0]         cat,
    input  logic [SCORE_W-1:0] score,
    output logic [NUM_CAT-1:0] used,
    output logic [TOTAL_W-1:0] total
);
    logic [NUM_CAT-1:0] used_q;
    logic [TOTAL_W-1:0] total_q;

`ifdef YACHT_UPPER_BONUS_EN
    logic [6:0] upper_q;
    logic       bonus_q;
    logic [7:0] upper_d;
    logic       bonus_hit;

    always_comb begin
        upper_d = {1'b0, upper_q};
        if (cat <= CAT_SIXES) upper_d = {1'b0, upper_q} + score;
        // Flag guards against a second award once the threshold is crossed.
        bonus_hit = !bonus_q && (upper_d >= 8'(BONUS_THRESH));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            used_q  <= '0;
            total_q <= '0;
            upper_q <= '0;
            bonus_q <= 1'b0;
        end else if (we) begin
            used_q[cat] <= 1'b1;
            upper_q     <= upper_d[6:0];
            total_q     <= total_q + TOTAL_W'(score) + (bonus_hit ? TOTAL_W'(BONUS_VAL) : '0);
            if (bonus_hit) bonus_q <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (clr) begin
            used_q  <= '0;
            total_q <= '0;
        end else if (we) begin
            used_q[cat] <= 1'b1;
            total_q     <= total_q + TOTAL_W'(score);
        end
    end
`endif

    assign used  = used_q;
    assign total = total_q;
endmodule

// File: rtl/yacht_scorecard_ctrl.sv
// Two-player scorecard controller time-sharing the score calculator between
// preview, commit and best-category scan. Option: YACHT_UPPER_BONUS_EN.
module yacht_scorecard_ctrl
    import yacht_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               player,
    input  logic [3:0]         view_cat,
    input  logic               scan_start,
    input  logic               commit_req,
    input  logic [3:0]         commit_cat,
    output logic               commit_ack,
    output logic               commit_err,
    output logic [3:0]         calc_cat,
    input  logic [SCORE_W-1:0] calc_score,
    output logic               busy,
    output logic               best_valid,
    output logic [3:0]         best_cat,
    output logic [SCORE_W-1:0] best_score,
    output logic [NUM_CAT-1:0] used_mask,
    output logic [TOTAL_W-1:0] p1_total,
    output logic [TOTAL_W-1:0] p2_total,
    output logic               game_over
);
    state_t             state_q;
    logic [3:0]         cat_q, idx_q, best_cat_q;
    logic [SCORE_W-1:0] best_score_q;
    logic               cplayer_q, splayer_q, prev_player_q;
    logic               ack_q, err_q, busy_q, best_valid_q;
    logic [NUM_CAT-1:0] p1_used, p2_used, scan_used;
    logic [15:0]        used_ext;
    logic               clr, we_p1, we_p2;

    assign clr       = reset || new_game;
    assign we_p1     = (state_q == ST_COMMIT) && !cplayer_q;
    assign we_p2     = (state_q == ST_COMMIT) && cplayer_q;
    assign used_mask = player ? p2_used : p1_used;
    assign used_ext  = {4'b0, used_mask};
    assign scan_used = splayer_q ? p2_used : p1_used;

    always_comb begin
        calc_cat = view_cat;
        case (state_q)
            ST_SCAN:   calc_cat = idx_q;
            ST_COMMIT: calc_cat = cat_q;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            cat_q         <= '0;
            idx_q         <= '0;
            cplayer_q     <= 1'b0;
            splayer_q     <= 1'b0;
            prev_player_q <= player;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            best_valid_q  <= 1'b0;
            best_cat_q    <= CAT_NONE;
            best_score_q  <= '0;
        end else begin
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            prev_player_q <= player;
            if (player != prev_player_q) best_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The requester still holds commit_req during the ack/err cycle.
                    if (commit_req && !ack_q && !err_q) begin
                        if (commit_cat >= 4'(NUM_CAT) || used_ext[commit_cat]) begin
                            err_q <= 1'b1;
                        end else begin
                            cat_q     <= commit_cat;
                            cplayer_q <= player;
                            state_q   <= ST_COMMIT;
                            busy_q    <= 1'b1;
                        end
                    end else if (scan_start) begin
                        idx_q        <= '0;
                        splayer_q    <= player;
                        best_valid_q <= 1'b0;
                        best_cat_q   <= CAT_NONE;
                        best_score_q <= '0;
                        state_q      <= ST_SCAN;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!scan_used[idx_q] && (best_cat_q == CAT_NONE || calc_score > best_score_q)) begin
                        best_cat_q   <= idx_q;
                        best_score_q <= calc_score;
                    end
                    if (idx_q == 4'(NUM_CAT - 1)) begin
                        best_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_COMMIT: begin
                    ack_q        <= 1'b1;
                    best_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    yacht_player_card u_card_p1 (
        .clk(clk), .clr(clr), .we(we_p1), .cat(cat_q), .score(calc_score),
        .used(p1_used), .total(p1_total)
    );

    yacht_player_card u_card_p2 (
        .clk(clk), .clr(clr), .we(we_p2), .cat(cat_q), .score(calc_score),
        .used(p2_used), .total(p2_total)
    );

    assign commit_ack = ack_q;
    assign commit_err = err_q;
    assign busy       = busy_q;
    assign best_valid = best_valid_q;
    assign best_cat   = best_cat_q;
    assign best_score = best_score_q;
    assign game_over  = (&p1_used) && (&p2_used);
endmodule

// File: tb/tb_yacht_scorecard_ctrl.sv
// Randomized self-checking bench for yacht_scorecard_ctrl against a scorecard model.
module tb_yacht_scorecard_ctrl;
    logic       clk = 1'b0;
    logic       reset, new_game, player, scan_start, commit_req;
    logic [3:0] view_cat, commit_cat, calc_cat, best_cat;
    logic [7:0] calc_score, best_score;
    logic       commit_ack, commit_err, busy, best_valid, game_over;
    logic [11:0] used_mask;
    logic [8:0] p1_total, p2_total;

    logic [7:0] tbl [16];
    assign calc_score = tbl[calc_cat];

    int chk = 0, pass = 0;
    bit [11:0] m_used [2];
    int m_tot [2], m_up [2];
    bit m_bonus [2];

    yacht_scorecard_ctrl dut (
        .clk(clk), .reset(reset), .new_game(new_game), .player(player), .view_cat(view_cat),
        .scan_start(scan_start), .commit_req(commit_req), .commit_cat(commit_cat),
        .commit_ack(commit_ack), .commit_err(commit_err), .calc_cat(calc_cat),
        .calc_score(calc_score), .busy(busy), .best_valid(best_valid), .best_cat(best_cat),
        .best_score(best_score), .used_mask(used_mask), .p1_total(p1_total),
        .p2_total(p2_total), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic void m_clear();
        for (int p = 0; p < 2; p++) begin
            m_used[p] = '0; m_tot[p] = 0; m_up[p] = 0; m_bonus[p] = 1'b0;
        end
    endfunction

    function automatic void m_apply(input int p, input int c, input int s);
        m_used[p][c] = 1'b1;
        m_tot[p] += s;
`ifdef YACHT_UPPER_BONUS_EN
        if (c <= 5) m_up[p] += s;
        if (!m_bonus[p] && m_up[p] >= 63) begin
            m_tot[p] += 35;
            m_bonus[p] = 1'b1;
        end
`endif
    endfunction

    // Highest score among unused categories, lowest index on ties.
    function automatic void m_best(input int p, output int bc, output int bs);
        int mx = -1;
        for (int c = 0; c < 12; c++) if (!m_used[p][c] && int'(tbl[c]) > mx) mx = int'(tbl[c]);
        bc = 15; bs = 0;
        if (mx >= 0) begin
            bs = mx;
            for (int c = 11; c >= 0; c--) if (!m_used[p][c] && int'(tbl[c]) == mx) bc = c;
        end
    endfunction

    function automatic int rand_score(input int c);
        return (c <= 5) ? int'($urandom_range(0, 5 * (c + 1))) : int'($urandom_range(0, 50));
    endfunction

    task automatic do_commit(input int p, input int c, input int s);
        bit ok;
        ok = (c < 12) && !m_used[p][c];
        if (c < 12) tbl[c] = 8'(s);
        player = p[0]; commit_cat = 4'(c); commit_req = 1'b1;
        step();
        if (ok) begin
            chk++; if (busy !== 1'b1) $display("FAIL commit_busy: got %0b want 1", busy); else pass++;
            chk++; if (calc_cat !== 4'(c)) $display("FAIL commit_calc_cat: got %0d want %0d", calc_cat, c); else pass++;
            chk++; if (commit_ack !== 1'b0) $display("FAIL ack_early: got %0b want 0", commit_ack); else pass++;
            step();
            m_apply(p, c, s);
            chk++; if (commit_ack !== 1'b1) $display("FAIL ack: cat %0d got %0b want 1", c, commit_ack); else pass++;
            chk++; if (p1_total !== 9'(m_tot[0])) $display("FAIL p1_total: got %0d want %0d", p1_total, m_tot[0]); else pass++;
            chk++; if (p2_total !== 9'(m_tot[1])) $display("FAIL p2_total: got %0d want %0d", p2_total, m_tot[1]); else pass++;
            chk++; if (used_mask !== m_used[p]) $display("FAIL used_mask: got %h want %h", used_mask, m_used[p]); else pass++;
            step();
            chk++; if (commit_ack !== 1'b0 || busy !== 1'b0) $display("FAIL ack_once: got ack %0b busy %0b want 0 0", commit_ack, busy); else pass++;
        end else begin
            chk++; if (commit_err !== 1'b1) $display("FAIL err: cat %0d got %0b want 1", c, commit_err); else pass++;
            chk++; if (busy !== 1'b0) $display("FAIL err_busy: got %0b want 0", busy); else pass++;
            step();
            chk++; if (commit_err !== 1'b0) $display("FAIL err_once: got %0b want 0", commit_err); else pass++;
            chk++; if (p1_total !== 9'(m_tot[0]) || p2_total !== 9'(m_tot[1])) $display("FAIL err_totals: got %0d/%0d want %0d/%0d", p1_total, p2_total, m_tot[0], m_tot[1]); else pass++;
            chk++; if (used_mask !== m_used[p]) $display("FAIL err_mask: got %h want %h", used_mask, m_used[p]); else pass++;
        end
        commit_req = 1'b0;
    endtask

    task automatic do_scan(input int p);
        int bc, bs;
        m_best(p, bc, bs);
        player = p[0]; scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk++; if (busy !== 1'b1 || calc_cat !== 4'(i) || best_valid !== 1'b0) $display("FAIL scan_cycle%0d: got busy %0b cat %0d valid %0b want 1 %0d 0", i, busy, calc_cat, best_valid, i); else pass++;
            step();
        end
        chk++; if (busy !== 1'b0 || best_valid !== 1'b1) $display("FAIL scan_done: got busy %0b valid %0b want 0 1", busy, best_valid); else pass++;
        chk++; if (best_cat !== 4'(bc) || best_score !== 8'(bs)) $display("FAIL scan_best: got %0d/%0d want %0d/%0d", best_cat, best_score, bc, bs); else pass++;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1; step(); new_game = 1'b0; m_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1; new_game = 0; player = 0; scan_start = 0; commit_req = 0; commit_cat = 0;
        view_cat = 4'($urandom_range(0, 11));
        for (int c = 0; c < 16; c++) tbl[c] = 8'($urandom_range(0, 30));
        m_clear();
        step(); step();
        reset = 1'b0;
        step();
        chk++; if (commit_ack !== 0 || commit_err !== 0 || busy !== 0 || best_valid !== 0) $display("FAIL reset_ctl: got ack %0b err %0b busy %0b valid %0b want 0", commit_ack, commit_err, busy, best_valid); else pass++;
        chk++; if (best_cat !== 4'hF || best_score !== 8'd0) $display("FAIL reset_best: got %0d/%0d want 15/0", best_cat, best_score); else pass++;
        chk++; if (used_mask !== 12'd0 || p1_total !== 9'd0 || p2_total !== 9'd0 || game_over !== 1'b0) $display("FAIL reset_card: got %h %0d %0d %0b want 0", used_mask, p1_total, p2_total, game_over); else pass++;
        chk++; if (calc_cat !== view_cat) $display("FAIL reset_view: got %0d want %0d", calc_cat, view_cat); else pass++;
    endtask

    task automatic test_commit_basic();
        do_commit(0, 11, 12);
        chk++; if (p1_total !== 9'd12 || used_mask[11] !== 1'b1) $display("FAIL yacht_commit: got %0d bit %0b want 12 1", p1_total, used_mask[11]); else pass++;
        do_commit(0, 11, 40);
        chk++; if (p1_total !== 9'd12) $display("FAIL repeat_total: got %0d want 12", p1_total); else pass++;
    endtask

    task automatic test_bad_cat();
        do_commit(0, 12, 0);
        do_commit(1, 15, 0);
        do_commit(1, $urandom_range(12, 15), 0);
    endtask

    task automatic test_scan_best();
        pulse_new_game();
        do_commit(0, 0, 3); do_commit(0, 3, 8); do_commit(0, 7, 20);
        for (int c = 0; c < 12; c++) tbl[c] = 8'($urandom_range(0, 23));
        tbl[0] = 30; tbl[3] = 31; tbl[7] = 32; tbl[5] = 24; tbl[6] = 24;
        do_scan(0);
        chk++; if (best_cat !== 4'd5 || best_score !== 8'd24) $display("FAIL tie_low: got %0d/%0d want 5/24", best_cat, best_score); else pass++;
        player = 1'b1; step();
        chk++; if (best_valid !== 1'b0) $display("FAIL valid_player_clr: got %0b want 0", best_valid); else pass++;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 12; c++) tbl[c] = 8'($urandom_range(0, 8));
            do_scan(r % 2);
        end
    endtask

    task automatic test_back_to_back();
        int c, s, bc, bs;
        m_best(1, bc, bs);
        c = 9; s = rand_score(c);
        player = 1'b1; scan_start = 1'b1;
        step(); scan_start = 1'b0;
        step(); step();
        commit_cat = 4'(c); commit_req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk++; if (best_valid !== 1'b1 || busy !== 1'b0 || commit_ack !== 1'b0) $display("FAIL ovl_scan_end: got valid %0b busy %0b ack %0b want 1 0 0", best_valid, busy, commit_ack); else pass++;
        chk++; if (best_cat !== 4'(bc) || best_score !== 8'(bs)) $display("FAIL ovl_best: got %0d/%0d want %0d/%0d", best_cat, best_score, bc, bs); else pass++;
        tbl[c] = 8'(s);
        step();
        chk++; if (busy !== 1'b1 || commit_ack !== 1'b0) $display("FAIL ovl_commit: got busy %0b ack %0b want 1 0", busy, commit_ack); else pass++;
        step();
        m_apply(1, c, s);
        chk++; if (commit_ack !== 1'b1 || best_valid !== 1'b0) $display("FAIL ovl_ack: got ack %0b valid %0b want 1 0", commit_ack, best_valid); else pass++;
        chk++; if (p2_total !== 9'(m_tot[1])) $display("FAIL ovl_total: got %0d want %0d", p2_total, m_tot[1]); else pass++;
        step(); commit_req = 1'b0;
    endtask

    task automatic test_new_game_abort();
        player = 1'b0; scan_start = 1'b1;
        step(); scan_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        new_game = 1'b1; step(); new_game = 1'b0; m_clear();
        chk++; if (busy !== 1'b0 || commit_ack !== 1'b0 || best_valid !== 1'b0) $display("FAIL ng_scan: got busy %0b ack %0b valid %0b want 0", busy, commit_ack, best_valid); else pass++;
        chk++; if (p1_total !== 9'd0 || p2_total !== 9'd0 || used_mask !== 12'd0) $display("FAIL ng_clear: got %0d %0d %h want 0", p1_total, p2_total, used_mask); else pass++;
        do_commit(0, 6, 17);
        commit_cat = 4'd8; commit_req = 1'b1; tbl[8] = 8'd25;
        step();
        commit_req = 1'b0; new_game = 1'b1;
        step(); new_game = 1'b0; m_clear();
        chk++; if (commit_ack !== 1'b0 || p1_total !== 9'd0 || busy !== 1'b0) $display("FAIL ng_commit: got ack %0b total %0d busy %0b want 0", commit_ack, p1_total, busy); else pass++;
        step();
        chk++; if (commit_ack !== 1'b0 || used_mask !== 12'd0) $display("FAIL ng_noack: got ack %0b mask %h want 0", commit_ack, used_mask); else pass++;
    endtask

    task automatic test_bonus();
        int sc [6] = '{3, 8, 12, 16, 20, 6};
        pulse_new_game();
        for (int c = 0; c < 6; c++) do_commit(1, c, sc[c]);
`ifdef YACHT_UPPER_BONUS_EN
        chk++; if (p2_total !== 9'd100) $display("FAIL bonus_total: got %0d want 100", p2_total); else pass++;
`else
        chk++; if (p2_total !== 9'd65) $display("FAIL plain_total: got %0d want 65", p2_total); else pass++;
`endif
        do_commit(1, 6, 30);
        chk++; if (p2_total !== 9'(m_tot[1])) $display("FAIL bonus_once: got %0d want %0d", p2_total, m_tot[1]); else pass++;
    endtask

    task automatic test_game_over();
        int perm [2][12];
        pulse_new_game();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 12; i++) perm[p][i] = i;
            for (int i = 11; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = perm[p][i]; perm[p][i] = perm[p][j]; perm[p][j] = t;
            end
        end
        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < 2; p++) begin
                chk++; if (game_over !== 1'b0) $display("FAIL game_over_early: got %0b want 0", game_over); else pass++;
                do_commit(p, perm[p][r], rand_score(perm[p][r]));
                if ($urandom_range(0, 3) == 0) do_commit(p, perm[p][$urandom_range(0, r)], 5);
            end
        end
        chk++; if (game_over !== 1'b1) $display("FAIL game_over: got %0b want 1", game_over); else pass++;
        do_scan(0);
        chk++; if (best_cat !== 4'hF || best_score !== 8'd0) $display("FAIL full_scan: got %0d/%0d want 15/0", best_cat, best_score); else pass++;
    endtask

    initial begin
        test_reset();
        test_commit_basic();
        test_bad_cat();
        test_scan_best();
        test_back_to_back();
        test_new_game_abort();
        test_bonus();
        test_game_over();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
